mips_datapath_decode_operand: RTL and testbench
===============================================

Name: mips_datapath_decode_operand

Overview:
- ID→EX operand stage. Sits directly downstream of the register file; consumes its two combinational read ports.
- Resolves RAW hazards by forwarding from the EX, MEM and WB stages. The register file has no internal write-to-read bypass, so the WB path is mandatory.
- Detects load-use hazards and inserts a one-cycle bubble.
- Registers the ID/EX operand bundle, with flush and downstream-hold support.

Parameters:
- RESET, Word'(0): value loaded into exA/exB on reset, flush and bubble.
- FORWARD, 1: when 0, all bypass paths are disabled, operands come from the register file only, and load-use stalls still apply.

Ports:
- ctrl  input  Data_Control_Control_T  control bundle. Clock and reset. One clock; reset is synchronous and active-high.
- idValid  input  1  ID instruction is valid.
- idRs  input  RegAddr(5)  rs field; also drives register-file rd1Addr.
- idRt  input  RegAddr(5)  rt field; also drives rd2Addr.
- idUsesRs  input  1  instruction reads rs.
- idUsesRt  input  1  instruction reads rt.
- idDest  input  RegAddr(5)  destination register of the ID instruction.
- idWrEnable  input  1  ID instruction writes idDest.
- idIsLoad  input  1  ID instruction is a load.
- rd1Data  input  Word(32)  register-file read port 1.
- rd2Data  input  Word(32)  register-file read port 2.
- exResult  input  Word(32)  combinational ALU result of the EX instruction.
- memWrAddr  input  5  MEM stage destination.
- memWrEnable  input  1  MEM stage writes memWrAddr.
- memData  input  32  MEM stage final value, including load data.
- wbWrAddr  input  5  WB stage destination; equals register-file wrAddr.
- wbWrEnable  input  1  WB stage write enable.
- wbData  input  32  WB stage data.
- flush  input  1  kill the ID instruction (branch/jump redirect).
- hold  input  1  downstream stall; freeze all EX registers.
- stall  output  1  combinational; IF/ID must hold its contents.
- exValid  output  1  registered valid.
- exA  output  32  registered operand A.
- exB  output  32  registered operand B.
- exRs  output  5  registered rs.
- exRt  output  5  registered rt.
- exDest  output  5  registered destination.
- exWrEnable  output  1  registered write enable.
- exIsLoad  output  1  registered load flag.

Behaviour:

Reset
- On a rising edge with reset asserted: exValid=0, exWrEnable=0, exIsLoad=0, exA=exB=RESET, exRs=exRt=exDest=0.
- Reset overrides every other input, including mid-stall.

Forwarding (combinational, per operand)
- Applies to operand A using idRs/rd1Data; identical for operand B using idRt/rd2Data.
- Address 0: never forwarded; always reads rd data (regfile returns 0).
- Priority, highest first:
  1. EX: exValid & exWrEnable & !exIsLoad & exDest==addr → exResult.
  2. MEM: memWrEnable & memWrAddr==addr → memData.
  3. WB: wbWrEnable & wbWrAddr==addr → wbData.
  4. Otherwise rd data.

Load-use stall
- loadUse = exValid & exIsLoad & exWrEnable & exDest≠0 & ((idUsesRs & exDest==idRs) | (idUsesRt & exDest==idRt)).
- stall = idValid & loadUse & !hold & !flush.
- Stall length is exactly one cycle: after the bubble the load sits in MEM and the MEM bypass covers it.

Per-edge update priority (highest first)
1. reset: as above.
2. hold: all EX registers keep their values; stall=0 (upstream is frozen by the same hold).
3. flush: bubble; exValid=0, exWrEnable=0, exIsLoad=0, exA=exB=RESET.
4. stall: bubble (same values as flush); the ID inputs are re-presented next cycle.
5. Normal: capture idValid, the forwarded operands, and the id* fields.
   - exWrEnable = idWrEnable & idValid & idDest≠0.
   - exIsLoad = idIsLoad & idValid.

Latency and boundaries
- Latency ID→EX is 1 cycle; 2 cycles when a load-use stall occurs.
- A bubble must never forward: exValid=0 blocks the EX path even if exDest matches.
- Simultaneous flush and load-use: flush wins; stall=0.
- Hold plus a pending load-use: re-evaluated after hold releases; no double bubble.
- rs==rt: both operands receive the identical forwarded value.

Decomposition:
- Shared package Mips_Type_Pipe: ID/EX bundle typedef (valid, A, B, rs, rt, dest, wrEnable, isLoad) and the bubble constant.
- Reuse the existing Word and RegAddr types.
- One sub-module, mips_datapath_forward_select, instantiated twice: inputs addr, rdData, and the three bypass sources; output the selected word.

Test Plan:
1. Reset, then idValid=1, idRs=3, rd1Data=7, no bypass matches → next edge exA=7, exValid=1. Asserting reset while exValid=1 → exValid=0, exA=0.
2. EX holds an ALU op writing r5 with exResult=0x11; MEM writes r5=0x22; WB writes r5=0x33; ID reads rs=5 → exA=0x11. Drop the EX match → exA=0x22. Drop the MEM match → exA=0x33.
3. Load to r8 in EX; ID uses rt=8 → stall=1 for one cycle and exValid=0 after the edge. Next cycle memWrAddr=8, memData=0xBEEF → exB=0xBEEF, stall=0.
4. Load to r0 in EX, ID uses r0 → stall=0. WB writes r0=5 → exA=rd1Data (0), not 5.
5. flush=1 coincident with a load-use match → stall=0 and a bubble enters EX. hold=1 for 3 cycles → EX outputs stable, stall=0.
6. FORWARD=0 with MEM writing r4=9 while rd1Data=1 → exA=1; the load-use stall still fires.

Source files
------------

// File: rtl/mips_datapath_decode_operand_pkg.sv
// ---------------------------------------------------------------------------
// Mips_Type_Pipe
//
// Shared types for the ID->EX operand stage of the MIPS datapath.
//
//    Word                    32-bit datapath word
//    RegAddr                 5-bit architectural register index
//    Data_Control_Control_T  clock/reset control bundle (clk, reset)
//    Bypass_Source_T         one forwarding producer: write enable,
//                            destination register and result word
//    Id_Ex_Bundle_T          contents of the ID/EX pipeline register
//    ID_EX_BUBBLE            empty ID/EX slot (operands zero)
//    bubble_bundle()         empty slot with the operand fill word supplied
//    bypass_hit()            does a producer write the register being read
// ---------------------------------------------------------------------------
package Mips_Type_Pipe;

   typedef logic [31:0] Word;
   typedef logic [4:0]  RegAddr;

   typedef struct packed {
      logic clk;
      logic reset;
   } Data_Control_Control_T;

   typedef struct packed {
      logic   en;
      RegAddr addr;
      Word    data;
   } Bypass_Source_T;

   typedef struct packed {
      logic   valid;
      Word    a;
      Word    b;
      RegAddr rs;
      RegAddr rt;
      RegAddr dest;
      logic   wrEnable;
      logic   isLoad;
   } Id_Ex_Bundle_T;

   localparam Id_Ex_Bundle_T ID_EX_BUBBLE = '{
      valid:    1'b0,
      a:        '0,
      b:        '0,
      rs:       '0,
      rt:       '0,
      dest:     '0,
      wrEnable: 1'b0,
      isLoad:   1'b0
   };

   // The operand fill of a bubble is a design parameter, so the package
   // provides the empty slot and lets the stage choose the operand value.
   function automatic Id_Ex_Bundle_T bubble_bundle(input Word fill);
      Id_Ex_Bundle_T b;
      b   = ID_EX_BUBBLE;
      b.a = fill;
      b.b = fill;
      return b;
   endfunction

   function automatic logic bypass_hit(input Bypass_Source_T src, input RegAddr addr);
      return src.en && (src.addr == addr);
   endfunction

endpackage

// File: rtl/mips_datapath_forward_select.sv
// ---------------------------------------------------------------------------
// mips_datapath_forward_select
//
// Chooses the freshest value of one source register. The youngest producer
// wins: EX, then MEM, then WB, then the register-file read data. Register 0
// is hard-wired to zero and is never bypassed.
//
// Parameters
//    FORWARD   0 disables every bypass path (register-file data only)
// Ports
//    addr      register being read
//    rdData    register-file read data for addr
//    exSrc     EX producer (enable already qualified by valid/non-load)
//    memSrc    MEM producer
//    wbSrc     WB producer
//    selData   selected operand word
// ---------------------------------------------------------------------------
module mips_datapath_forward_select
   import Mips_Type_Pipe::*;
#(
   parameter bit FORWARD = 1'b1
)
(
   input  RegAddr         addr,
   input  Word            rdData,
   input  Bypass_Source_T exSrc,
   input  Bypass_Source_T memSrc,
   input  Bypass_Source_T wbSrc,
   output Word            selData
);

   // Priority chain, youngest producer first.
   always_comb begin
      selData = rdData;
      if (FORWARD && (addr != '0)) begin
         if (bypass_hit(exSrc, addr)) begin
            selData = exSrc.data;
         end else if (bypass_hit(memSrc, addr)) begin
            selData = memSrc.data;
         end else if (bypass_hit(wbSrc, addr)) begin
            selData = wbSrc.data;
         end
      end
   end

endmodule

// File: rtl/mips_datapath_decode_operand.sv
// ---------------------------------------------------------------------------
// mips_datapath_decode_operand
//
// ID->EX operand stage. Reads both register-file ports, resolves RAW hazards
// by forwarding from EX, MEM and WB, detects load-use hazards (one-cycle
// bubble) and registers the ID/EX operand bundle with flush and hold.
//
// Parameters
//    RESET      operand value loaded on reset, flush and bubble
//    FORWARD    0 disables all bypass paths (load-use stall still applies)
// Ports
//    ctrl         clock and synchronous active-high reset
//    idValid      ID instruction valid
//    idRs/idRt    source registers (also the register-file read addresses)
//    idUsesRs/Rt  instruction actually reads rs / rt
//    idDest       destination register
//    idWrEnable   instruction writes idDest
//    idIsLoad     instruction is a load
//    rd1Data/rd2Data  register-file read data
//    exResult     combinational ALU result of the EX instruction
//    memWrAddr/memWrEnable/memData  MEM producer
//    wbWrAddr/wbWrEnable/wbData     WB producer (register-file write port)
//    flush        kill the ID instruction
//    hold         downstream stall, freeze the EX registers
//    stall        IF/ID must hold its contents
//    exValid..exIsLoad  registered ID/EX bundle
// ---------------------------------------------------------------------------
module mips_datapath_decode_operand
   import Mips_Type_Pipe::*;
#(
   parameter Word RESET   = Word'(0),
   parameter bit  FORWARD = 1'b1
)
(
   input  Data_Control_Control_T ctrl,
   input  logic                  idValid,
   input  RegAddr                idRs,
   input  RegAddr                idRt,
   input  logic                  idUsesRs,
   input  logic                  idUsesRt,
   input  RegAddr                idDest,
   input  logic                  idWrEnable,
   input  logic                  idIsLoad,
   input  Word                   rd1Data,
   input  Word                   rd2Data,
   input  Word                   exResult,
   input  RegAddr                memWrAddr,
   input  logic                  memWrEnable,
   input  Word                   memData,
   input  RegAddr                wbWrAddr,
   input  logic                  wbWrEnable,
   input  Word                   wbData,
   input  logic                  flush,
   input  logic                  hold,
   output logic                  stall,
   output logic                  exValid,
   output Word                   exA,
   output Word                   exB,
   output RegAddr                exRs,
   output RegAddr                exRt,
   output RegAddr                exDest,
   output logic                  exWrEnable,
   output logic                  exIsLoad
);

   localparam Id_Ex_Bundle_T BUBBLE = bubble_bundle(RESET);

   Id_Ex_Bundle_T  ex_q;
   Id_Ex_Bundle_T  ex_d;
   Bypass_Source_T ex_src;
   Bypass_Source_T mem_src;
   Bypass_Source_T wb_src;
   Word            fwd_a;
   Word            fwd_b;
   logic           load_use;

   // A load in EX has no data yet, so it is excluded from the EX bypass;
   // a bubble (valid=0) must never forward even if its dest field matches.
   assign ex_src  = '{en: ex_q.valid & ex_q.wrEnable & ~ex_q.isLoad,
                      addr: ex_q.dest, data: exResult};
   assign mem_src = '{en: memWrEnable, addr: memWrAddr, data: memData};
   assign wb_src  = '{en: wbWrEnable,  addr: wbWrAddr,  data: wbData};

   mips_datapath_forward_select #(.FORWARD(FORWARD)) u_fwd_a (
      .addr    (idRs),
      .rdData  (rd1Data),
      .exSrc   (ex_src),
      .memSrc  (mem_src),
      .wbSrc   (wb_src),
      .selData (fwd_a)
   );

   mips_datapath_forward_select #(.FORWARD(FORWARD)) u_fwd_b (
      .addr    (idRt),
      .rdData  (rd2Data),
      .exSrc   (ex_src),
      .memSrc  (mem_src),
      .wbSrc   (wb_src),
      .selData (fwd_b)
   );

   // One bubble suffices: after it the load sits in MEM and the MEM bypass
   // delivers its data. Hold and flush suppress the stall because upstream
   // is already frozen or the ID instruction is being discarded.
   assign load_use = ex_q.valid & ex_q.isLoad & ex_q.wrEnable & (ex_q.dest != '0)
                   & ((idUsesRs & (ex_q.dest == idRs)) | (idUsesRt & (ex_q.dest == idRt)));
   assign stall    = idValid & load_use & ~hold & ~flush;

   // Next-state selection: hold, then flush/stall bubble, then normal capture.
   always_comb begin
      ex_d = ex_q;
      if (hold) begin
         ex_d = ex_q;
      end else if (flush || stall) begin
         ex_d = BUBBLE;
      end else begin
         ex_d.valid    = idValid;
         ex_d.a        = fwd_a;
         ex_d.b        = fwd_b;
         ex_d.rs       = idRs;
         ex_d.rt       = idRt;
         ex_d.dest     = idDest;
         ex_d.wrEnable = idWrEnable & idValid & (idDest != '0);
         ex_d.isLoad   = idIsLoad & idValid;
      end
   end

   // ID/EX pipeline register; reset overrides everything, including hold.
   always_ff @(posedge ctrl.clk) begin
      if (ctrl.reset) begin
         ex_q <= BUBBLE;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign exValid    = ex_q.valid;
   assign exA        = ex_q.a;
   assign exB        = ex_q.b;
   assign exRs       = ex_q.rs;
   assign exRt       = ex_q.rt;
   assign exDest     = ex_q.dest;
   assign exWrEnable = ex_q.wrEnable;
   assign exIsLoad   = ex_q.isLoad;

endmodule

// File: tb/tb_mips_datapath_decode_operand.sv
// ---------------------------------------------------------------------------
// tb_mips_datapath_decode_operand
//
// Drives two copies of the operand stage (forwarding on and off) with shared
// inputs. A reference model of the ID/EX register computes the expected
// outcome of every cycle and queues it; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_mips_datapath_decode_operand;
   import Mips_Type_Pipe::*;

   typedef struct {
      logic   rst;
      logic   idValid;
      RegAddr idRs;
      RegAddr idRt;
      logic   idUsesRs;
      logic   idUsesRt;
      RegAddr idDest;
      logic   idWrEnable;
      logic   idIsLoad;
      Word    rd1Data;
      Word    rd2Data;
      Word    exResult;
      RegAddr memWrAddr;
      logic   memWrEnable;
      Word    memData;
      RegAddr wbWrAddr;
      logic   wbWrEnable;
      Word    wbData;
      logic   flush;
      logic   hold;
   } stim_t;

   typedef struct {
      logic   check_stall;
      logic   check_fields;
      logic   stall;
      logic   valid;
      logic   wr;
      logic   load;
      Word    a;
      Word    b;
      Word    a_nf;
      Word    b_nf;
      RegAddr rs;
      RegAddr rt;
      RegAddr dest;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   Data_Control_Control_T ctrl;
   assign ctrl = '{clk: clk, reset: rst};
   always #5 clk = ~clk;

   logic   id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
   logic   id_wr_enable = 1'b0, id_is_load = 1'b0;
   RegAddr id_rs = '0, id_rt = '0, id_dest = '0, mem_wr_addr = '0, wb_wr_addr = '0;
   Word    rd1_data = '0, rd2_data = '0, ex_result = '0, mem_data = '0, wb_data = '0;
   logic   mem_wr_enable = 1'b0, wb_wr_enable = 1'b0, flush = 1'b0, hold = 1'b0;

   logic   stall, ex_valid, ex_wr_enable, ex_is_load;
   Word    ex_a, ex_b;
   RegAddr ex_rs, ex_rt, ex_dest;
   logic   stall_nf, ex_valid_nf, ex_wr_enable_nf, ex_is_load_nf;
   Word    ex_a_nf, ex_b_nf;
   RegAddr ex_rs_nf, ex_rt_nf, ex_dest_nf;

   mips_datapath_decode_operand #(.RESET(Word'(0)), .FORWARD(1'b1)) dut (
      .ctrl(ctrl), .idValid(id_valid), .idRs(id_rs), .idRt(id_rt),
      .idUsesRs(id_uses_rs), .idUsesRt(id_uses_rt), .idDest(id_dest),
      .idWrEnable(id_wr_enable), .idIsLoad(id_is_load),
      .rd1Data(rd1_data), .rd2Data(rd2_data), .exResult(ex_result),
      .memWrAddr(mem_wr_addr), .memWrEnable(mem_wr_enable), .memData(mem_data),
      .wbWrAddr(wb_wr_addr), .wbWrEnable(wb_wr_enable), .wbData(wb_data),
      .flush(flush), .hold(hold), .stall(stall), .exValid(ex_valid),
      .exA(ex_a), .exB(ex_b), .exRs(ex_rs), .exRt(ex_rt), .exDest(ex_dest),
      .exWrEnable(ex_wr_enable), .exIsLoad(ex_is_load)
   );

   mips_datapath_decode_operand #(.RESET(Word'(0)), .FORWARD(1'b0)) dut_nf (
      .ctrl(ctrl), .idValid(id_valid), .idRs(id_rs), .idRt(id_rt),
      .idUsesRs(id_uses_rs), .idUsesRt(id_uses_rt), .idDest(id_dest),
      .idWrEnable(id_wr_enable), .idIsLoad(id_is_load),
      .rd1Data(rd1_data), .rd2Data(rd2_data), .exResult(ex_result),
      .memWrAddr(mem_wr_addr), .memWrEnable(mem_wr_enable), .memData(mem_data),
      .wbWrAddr(wb_wr_addr), .wbWrEnable(wb_wr_enable), .wbData(wb_data),
      .flush(flush), .hold(hold), .stall(stall_nf), .exValid(ex_valid_nf),
      .exA(ex_a_nf), .exB(ex_b_nf), .exRs(ex_rs_nf), .exRt(ex_rt_nf), .exDest(ex_dest_nf),
      .exWrEnable(ex_wr_enable_nf), .exIsLoad(ex_is_load_nf)
   );

   exp_t scoreboard[$];
   int   check_count = 0;
   int   error_count = 0;

   // Reference model: the instruction currently sitting in EX.
   logic   m_ready = 1'b0;
   logic   m_known = 1'b0;
   logic   m_valid = 1'b0, m_wr = 1'b0, m_load = 1'b0;
   Word    m_a = '0, m_b = '0, m_a_nf = '0, m_b_nf = '0;
   RegAddr m_rs = '0, m_rt = '0, m_dest = '0;

   // Freshest architectural value of register r as seen by the ID stage.
   function automatic Word refOperand(input stim_t s, input RegAddr r, input Word regfile_val,
                                      input bit bypass_on);
      if (!bypass_on || r == 0) return regfile_val;
      if (m_valid && m_wr && !m_load && m_dest == r) return s.exResult;
      if (s.memWrEnable && s.memWrAddr == r) return s.memData;
      if (s.wbWrEnable && s.wbWrAddr == r) return s.wbData;
      return regfile_val;
   endfunction

   task automatic checkOutput(input string name, input Word got, input Word want);
      check_count++;
      if (got !== want) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      exp_t e;
      logic load_pending;
      Word  na, nb, na_nf, nb_nf;
      @(negedge clk);
      rst = s.rst; id_valid = s.idValid; id_rs = s.idRs; id_rt = s.idRt;
      id_uses_rs = s.idUsesRs; id_uses_rt = s.idUsesRt; id_dest = s.idDest;
      id_wr_enable = s.idWrEnable; id_is_load = s.idIsLoad;
      rd1_data = s.rd1Data; rd2_data = s.rd2Data; ex_result = s.exResult;
      mem_wr_addr = s.memWrAddr; mem_wr_enable = s.memWrEnable; mem_data = s.memData;
      wb_wr_addr = s.wbWrAddr; wb_wr_enable = s.wbWrEnable; wb_data = s.wbData;
      flush = s.flush; hold = s.hold;
      #1;
      load_pending = m_valid && m_load && m_wr && (m_dest != 0) &&
                     ((s.idUsesRs && m_dest == s.idRs) || (s.idUsesRt && m_dest == s.idRt));
      e.check_stall = m_ready;
      e.stall = s.idValid && load_pending && !s.hold && !s.flush;
      na    = refOperand(s, s.idRs, s.rd1Data, 1'b1);
      nb    = refOperand(s, s.idRt, s.rd2Data, 1'b1);
      na_nf = refOperand(s, s.idRs, s.rd1Data, 1'b0);
      nb_nf = refOperand(s, s.idRt, s.rd2Data, 1'b0);
      if (s.rst) begin
         m_ready = 1'b1; m_known = 1'b1;
         m_valid = 1'b0; m_wr = 1'b0; m_load = 1'b0;
         m_a = '0; m_b = '0; m_a_nf = '0; m_b_nf = '0;
         m_rs = '0; m_rt = '0; m_dest = '0;
      end else if (s.hold) begin
         // EX contents unchanged
      end else if (s.flush || e.stall) begin
         m_known = 1'b0;
         m_valid = 1'b0; m_wr = 1'b0; m_load = 1'b0;
         m_a = '0; m_b = '0; m_a_nf = '0; m_b_nf = '0;
      end else begin
         m_known = 1'b1;
         m_valid = s.idValid;
         m_wr    = s.idValid && s.idWrEnable && s.idDest != 0;
         m_load  = s.idValid && s.idIsLoad;
         m_a = na; m_b = nb; m_a_nf = na_nf; m_b_nf = nb_nf;
         m_rs = s.idRs; m_rt = s.idRt; m_dest = s.idDest;
      end
      e.check_fields = m_known;
      e.valid = m_valid; e.wr = m_wr; e.load = m_load;
      e.a = m_a; e.b = m_b; e.a_nf = m_a_nf; e.b_nf = m_b_nf;
      e.rs = m_rs; e.rt = m_rt; e.dest = m_dest;
      scoreboard.push_back(e);
   endtask

   // Monitor: stall is sampled mid-cycle, registers just after the edge.
   initial begin : monitor
      exp_t e;
      logic s_stall, s_stall_nf;
      forever begin
         @(negedge clk);
         #3;
         s_stall = stall;
         s_stall_nf = stall_nf;
         @(posedge clk);
         #1;
         if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_underflow", Word'(0), Word'(1));
         end else begin
            e = scoreboard.pop_front();
            if (e.check_stall) begin
               checkOutput("stall", Word'(s_stall), Word'(e.stall));
               checkOutput("stall_nofwd", Word'(s_stall_nf), Word'(e.stall));
            end
            checkOutput("exValid", Word'(ex_valid), Word'(e.valid));
            checkOutput("exWrEnable", Word'(ex_wr_enable), Word'(e.wr));
            checkOutput("exIsLoad", Word'(ex_is_load), Word'(e.load));
            checkOutput("exA", ex_a, e.a);
            checkOutput("exB", ex_b, e.b);
            checkOutput("exA_nofwd", ex_a_nf, e.a_nf);
            checkOutput("exB_nofwd", ex_b_nf, e.b_nf);
            checkOutput("exValid_nofwd", Word'(ex_valid_nf), Word'(e.valid));
            if (e.check_fields) begin
               checkOutput("exRs", Word'(ex_rs), Word'(e.rs));
               checkOutput("exRt", Word'(ex_rt), Word'(e.rt));
               checkOutput("exDest", Word'(ex_dest), Word'(e.dest));
            end
         end
      end
   end

   function automatic stim_t idleStim();
      stim_t s;
      s.rst = 1'b0; s.idValid = 1'b0; s.idRs = '0; s.idRt = '0;
      s.idUsesRs = 1'b0; s.idUsesRt = 1'b0; s.idDest = '0;
      s.idWrEnable = 1'b0; s.idIsLoad = 1'b0;
      s.rd1Data = '0; s.rd2Data = '0; s.exResult = '0;
      s.memWrAddr = '0; s.memWrEnable = 1'b0; s.memData = '0;
      s.wbWrAddr = '0; s.wbWrEnable = 1'b0; s.wbData = '0;
      s.flush = 1'b0; s.hold = 1'b0;
      return s;
   endfunction

   function automatic stim_t loadStim(input RegAddr dest);
      stim_t s;
      s = idleStim();
      s.idValid = 1'b1; s.idIsLoad = 1'b1; s.idWrEnable = 1'b1; s.idDest = dest;
      return s;
   endfunction

   // Small register range so hazards and matches are frequent.
   function automatic stim_t randomStim();
      stim_t s;
      s.rst        = ($urandom_range(0, 39) == 0);
      s.idValid    = ($urandom_range(0, 7) != 0);
      s.idRs       = RegAddr'($urandom_range(0, 7));
      s.idRt       = ($urandom_range(0, 3) == 0) ? s.idRs : RegAddr'($urandom_range(0, 7));
      s.idUsesRs   = ($urandom_range(0, 3) != 0);
      s.idUsesRt   = ($urandom_range(0, 1) != 0);
      s.idDest     = RegAddr'($urandom_range(0, 7));
      s.idWrEnable = ($urandom_range(0, 3) != 0);
      s.idIsLoad   = ($urandom_range(0, 2) == 0);
      s.rd1Data    = (s.idRs == 0) ? Word'(0) : Word'($urandom);
      s.rd2Data    = (s.idRt == 0) ? Word'(0) : Word'($urandom);
      s.exResult   = Word'($urandom);
      s.memWrAddr  = RegAddr'($urandom_range(0, 7));
      s.memWrEnable = ($urandom_range(0, 1) != 0);
      s.memData    = Word'($urandom);
      s.wbWrAddr   = RegAddr'($urandom_range(0, 7));
      s.wbWrEnable = ($urandom_range(0, 1) != 0);
      s.wbData     = Word'($urandom);
      s.flush      = ($urandom_range(0, 9) == 0);
      s.hold       = ($urandom_range(0, 7) == 0);
      return s;
   endfunction

   initial begin : stimulus
      stim_t s;
      // reset, then a plain register-file read, then reset while valid
      s = idleStim(); s.rst = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd3; s.idUsesRs = 1'b1; s.rd1Data = 32'd7;
      applyStimulus(s);
      s.rst = 1'b1;
      applyStimulus(s);

      // EX > MEM > WB priority on r5
      s = idleStim(); s.idValid = 1'b1; s.idDest = 5'd5; s.idWrEnable = 1'b1;
      applyStimulus(s);
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd5; s.idUsesRs = 1'b1; s.rd1Data = 32'h44;
      s.exResult = 32'h11; s.memWrEnable = 1'b1; s.memWrAddr = 5'd5; s.memData = 32'h22;
      s.wbWrEnable = 1'b1; s.wbWrAddr = 5'd5; s.wbData = 32'h33;
      applyStimulus(s);
      applyStimulus(s);
      s.memWrEnable = 1'b0;
      applyStimulus(s);

      // load-use on rt=8: one bubble, then MEM bypass supplies the load data
      applyStimulus(loadStim(5'd8));
      s = idleStim(); s.idValid = 1'b1; s.idRt = 5'd8; s.idUsesRt = 1'b1; s.rd2Data = 32'h1;
      applyStimulus(s);
      s.memWrEnable = 1'b1; s.memWrAddr = 5'd8; s.memData = 32'hBEEF;
      applyStimulus(s);

      // load to r0 never stalls; WB to r0 never forwards
      applyStimulus(loadStim(5'd0));
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd0; s.idUsesRs = 1'b1;
      s.wbWrEnable = 1'b1; s.wbWrAddr = 5'd0; s.wbData = 32'd5;
      applyStimulus(s);

      // flush beats load-use, then hold freezes EX for three cycles
      applyStimulus(loadStim(5'd8));
      s = idleStim(); s.idValid = 1'b1; s.idRt = 5'd8; s.idUsesRt = 1'b1; s.flush = 1'b1;
      applyStimulus(s);
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd2; s.rd1Data = 32'h99;
      applyStimulus(s);
      s.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s.rd1Data = Word'($urandom);
         applyStimulus(s);
      end

      // pending load-use under hold: no stall while held, single bubble after
      applyStimulus(loadStim(5'd6));
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd6; s.idUsesRs = 1'b1; s.hold = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      s.hold = 1'b0;
      applyStimulus(s);
      s.memWrEnable = 1'b1; s.memWrAddr = 5'd6; s.memData = 32'hCAFE;
      applyStimulus(s);

      // rs == rt both take the same bypassed word; MEM r4 bypass vs no-forward copy
      s = idleStim(); s.idValid = 1'b1; s.idRs = 5'd4; s.idRt = 5'd4;
      s.idUsesRs = 1'b1; s.idUsesRt = 1'b1; s.rd1Data = 32'd1; s.rd2Data = 32'd1;
      s.memWrEnable = 1'b1; s.memWrAddr = 5'd4; s.memData = 32'd9;
      applyStimulus(s);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(randomStim());
      end

      for (int k = 0; k < 4 && scoreboard.size() != 0; k++) begin
         @(posedge clk);
         #2;
      end
      checkOutput("scoreboard_drained", Word'(scoreboard.size()), Word'(0));
      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
